alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between two requesters: the pipeline EX stage (port 0) and the auxiliary address/compare unit (port 1). Port 0 has fixed priority, and an anti-starvation counter forces a port 1 grant after a bounded wait. The block drives the ALU operand and opcode inputs and registers the result and Zero flag into a tagged response one cycle after the grant. It sits between EX and the ALU and drives the EX stall signal.

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between the two requesters, the shared ALU and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding EX stage, aux unit and ALU.
interface alu_arbiter_if;
  logic        r0_req;
  logic [3:0]  r0_op;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic        r0_gnt;
  logic        r0_stall;
  logic        r1_req;
  logic [3:0]  r1_op;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic        r1_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_c;
  logic        rsp_zero;

  modport slave (
    input  r0_req, r0_op, r0_a, r0_b,
    input  r1_req, r1_op, r1_a, r1_b,
    input  alu_c, alu_zero,
    output r0_gnt, r0_stall, r1_gnt,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_c, rsp_zero
  );

  modport master (
    output r0_req, r0_op, r0_a, r0_b,
    output r1_req, r1_op, r1_a, r1_b,
    output alu_c, alu_zero,
    input  r0_gnt, r0_stall, r1_gnt,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_c, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for the shared ALU: port 0 fixed priority, port 1 forced after STARVE_LIMIT denials.
// Grant is combinational (0 cycles); the tagged result is registered and appears 1 cycle after the grant.
module alu_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_c_q, rsp_c_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        r0_gnt;
  logic        r1_gnt;
  logic        force_r1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;

  always_comb begin
    r0_gnt   = 1'b0;
    r1_gnt   = 1'b0;
    force_r1 = (starve_cnt_q == LIMIT) && bus.r1_req;
    if (!rst) begin
      if (force_r1)        r1_gnt = 1'b1;
      else if (bus.r0_req) r0_gnt = 1'b1;
      else if (bus.r1_req) r1_gnt = 1'b1;
    end
  end

  always_comb begin
    alu_op = 4'b0000;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (r0_gnt) begin
      alu_op = bus.r0_op;
      alu_a  = bus.r0_a;
      alu_b  = bus.r0_b;
    end else if (r1_gnt) begin
      alu_op = bus.r1_op;
      alu_a  = bus.r1_a;
      alu_b  = bus.r1_b;
    end
  end

  // A withdrawn or granted port 1 request restarts the starvation count.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (bus.r1_req && !r1_gnt)
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
  end

  always_comb begin
    rsp_valid_d = r0_gnt | r1_gnt;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    rsp_zero_d  = rsp_zero_q;
    if (r0_gnt || r1_gnt) begin
      rsp_id_d   = r1_gnt;
      rsp_c_d    = bus.alu_c;
      rsp_zero_d = bus.alu_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_c_q      <= 32'd0;
      rsp_zero_q   <= 1'b1;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_c_q      <= rsp_c_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.r0_gnt    = r0_gnt;
  assign bus.r1_gnt    = r1_gnt;
  assign bus.r0_stall  = bus.r0_req & ~r0_gnt;
  assign bus.alu_op    = alu_op;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the operand bus.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later or at the next falling edge.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_arbiter_if bus ();

  alu_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_op)
      4'b0010: bus.alu_c = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_c = bus.alu_a - bus.alu_b;
      4'b0001: bus.alu_c = bus.alu_a | bus.alu_b;
      4'b1000: bus.alu_c = {bus.alu_b[15:0], 16'h0000};
      default: bus.alu_c = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_c == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_r0(input logic req, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.r0_req = req; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
  endtask

  task automatic set_r1(input logic req, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.r1_req = req; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
  endtask

  task automatic rsp_chk(input string tag, input logic v, input logic id, input logic [31:0] c, input logic z);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
    chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    chk({tag, "_c"},     bus.rsp_c,          c);
    chk({tag, "_zero"},  32'(bus.rsp_zero),  32'(z));
  endtask

  initial begin
    logic [9:0] cont_r1;
    logic [8:0] clr_req;
    logic [8:0] clr_gnt;
    logic       prev_id;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset state, including a request held during reset
    @(negedge clk); @(negedge clk);
    set_r0(1'b1, 4'b0010, 32'd5, 32'd3);
    #1;
    rsp_chk("reset", 1'b0, 1'b0, 32'd0, 1'b1);
    chk("reset_r0_gnt", 32'(bus.r0_gnt), 32'd0);
    chk("reset_r1_gnt", 32'(bus.r1_gnt), 32'd0);
    chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
    chk("reset_alu_a",  bus.alu_a,       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // r0 add 5+3
    #1;
    chk("add_r0_gnt",   32'(bus.r0_gnt),   32'd1);
    chk("add_r0_stall", 32'(bus.r0_stall), 32'd0);
    chk("add_alu_op",   32'(bus.alu_op),   32'h2);
    chk("add_alu_a",    bus.alu_a,         32'd5);
    @(negedge clk);
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_chk("add", 1'b1, 1'b0, 32'd8, 1'b0);
    @(negedge clk);
    rsp_chk("idle_hold", 1'b0, 1'b0, 32'd8, 1'b0);
    chk("idle_alu_b", bus.alu_b, 32'd0);

    // r1 sub 7-7 with r0 idle
    set_r1(1'b1, 4'b0110, 32'd7, 32'd7);
    #1;
    chk("sub_r1_gnt", 32'(bus.r1_gnt), 32'd1);
    chk("sub_r0_gnt", 32'(bus.r0_gnt), 32'd0);
    @(negedge clk);
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_chk("sub", 1'b1, 1'b1, 32'd0, 1'b1);

    // shift B<<16
    set_r0(1'b1, 4'b1000, 32'd0, 32'h0000_0001);
    @(negedge clk);
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_chk("shl16", 1'b1, 1'b0, 32'h0001_0000, 1'b0);

    // illegal opcode
    set_r0(1'b1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_chk("illegal", 1'b1, 1'b0, 32'd0, 1'b1);

    // back-to-back or then add
    set_r0(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    rsp_chk("b2b_or", 1'b1, 1'b0, 32'h0000_00FF, 1'b0);
    set_r0(1'b1, 4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    rsp_chk("b2b_add", 1'b1, 1'b0, 32'd2, 1'b0);
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    rsp_chk("b2b_idle", 1'b0, 1'b0, 32'd2, 1'b0);

    // continuous contention: port 1 forced every fifth cycle
    cont_r1 = 10'b10000_10000;
    set_r0(1'b1, 4'b0010, 32'd10, 32'd20);
    set_r1(1'b1, 4'b0110, 32'd9, 32'd4);
    prev_id = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont%0d_r1_gnt", i),   32'(bus.r1_gnt),   32'(cont_r1[i]));
      chk($sformatf("cont%0d_r0_gnt", i),   32'(bus.r0_gnt),   32'(!cont_r1[i]));
      chk($sformatf("cont%0d_r0_stall", i), 32'(bus.r0_stall), 32'(cont_r1[i]));
      if (i > 0)
        rsp_chk($sformatf("cont%0d_rsp", i), 1'b1, prev_id, prev_id ? 32'd5 : 32'd30, 1'b0);
      prev_id = cont_r1[i];
      @(negedge clk);
    end

    // port 1 drops for one cycle: counter restarts, four more denials
    clr_req = 9'b1_1111_0111;
    clr_gnt = 9'b1_0000_0000;
    for (int i = 0; i < 9; i++) begin
      bus.r1_req = clr_req[i];
      #1;
      chk($sformatf("clr%0d_r1_gnt", i), 32'(bus.r1_gnt), 32'(clr_gnt[i]));
      chk($sformatf("clr%0d_r0_gnt", i), 32'(bus.r0_gnt), 32'(!clr_gnt[i]));
      @(negedge clk);
    end
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);

    // reset asserted while a response is valid and another grant is pending
    set_r0(1'b1, 4'b0010, 32'd5, 32'd3);
    @(negedge clk);
    rsp_chk("pre_rst", 1'b1, 1'b0, 32'd8, 1'b0);
    rst = 1'b1;
    #1;
    rsp_chk("mid_rst", 1'b0, 1'b0, 32'd0, 1'b1);
    chk("mid_rst_r0_gnt",   32'(bus.r0_gnt),   32'd0);
    chk("mid_rst_r1_gnt",   32'(bus.r1_gnt),   32'd0);
    chk("mid_rst_r0_stall", 32'(bus.r0_stall), 32'd1);
    @(negedge clk);
    rsp_chk("held_rst", 1'b0, 1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    #1;
    chk("post_rst_r0_gnt", 32'(bus.r0_gnt), 32'd1);
    @(negedge clk);
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_chk("post_rst", 1'b1, 1'b0, 32'd8, 1'b0);
    @(negedge clk);
    chk("post_rst_idle_valid", 32'(bus.rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
